noaa_mote_scheduler: RTL and testbench
======================================

Name: noaa_mote_scheduler

Overview:
- Round-robin scheduler that shares one NOAA statistics engine among NUM_CH temperature-mote channels. The engine computes the average or standard deviation of a sample window.
- Per job, the block:
  - grants one requesting channel;
  - clears the engine;
  - drives the channel's MODE;
  - steers that channel's 12-bit TN samples into the engine;
  - captures the engine's DONE/AVG_SD result;
  - returns the result through a valid/ack handshake.
- It sits between the mote sample front-ends and the engine instance.

Parameters:
- NUM_CH, 4: number of mote channels (2..8).
- CHW, 2: channel index width, equal to clog2(NUM_CH).
- TIMEOUT, 255: maximum cycles in RUN with no ENG_SAMPLE or ENG_DONE before the job is aborted.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ  in  NUM_CH  level request per channel; high means a job is pending.
- REQ_MODE  in  NUM_CH  per-channel mode (0=average, 1=std-dev); sampled at grant.
- CH_TN  in  NUM_CH*12  flattened sample inputs; channel i occupies bits [12i+11:12i].
- CH_SAMPLE  out  NUM_CH  one-hot strobe: the granted channel's sample was consumed this cycle.
- ENG_RESET  out  1  active-high clear to the engine.
- ENG_MODE  out  1  MODE input to the engine.
- ENG_TN  out  12  TN input to the engine.
- ENG_SAMPLE  in  1  engine SAMPLE strobe (sample consumed).
- ENG_DONE  in  1  engine DONE (ENG_AVG_SD valid).
- ENG_AVG_SD  in  12  engine result.
- RES_VALID  out  1  result available.
- RES_CH  out  CHW  channel the result belongs to.
- RES_DATA  out  12  captured result.
- RES_ERR  out  1  job aborted by timeout; RES_DATA=0.
- RES_ACK  in  1  consumer accepts the result.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state=IDLE, rr_ptr=NUM_CH-1, grant=0, ENG_MODE=0, ENG_RESET=1;
  - RES_VALID=0, RES_CH=0, RES_DATA=0, RES_ERR=0;
  - timeout counter cleared.
  - Reset asserted mid-job abandons the job silently; no result is produced.
- FSM states: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - ENG_RESET=1.
  - If REQ is nonzero at edge k, grant = first set REQ bit searching from rr_ptr+1 upward with wrap.
  - At that edge, ENG_MODE<=REQ_MODE[grant]; next state CLEAR.
  - If REQ=0, stay in IDLE.
- CLEAR:
  - Exactly one cycle with ENG_RESET=1; unconditionally goes to RUN.
  - ENG_SAMPLE and ENG_DONE are ignored.
- RUN:
  - ENG_RESET=0; ENG_TN = CH_TN slice of grant (combinational).
  - CH_SAMPLE[grant] = ENG_SAMPLE; all other CH_SAMPLE bits are 0.
  - On the first ENG_DONE, RES_DATA<=ENG_AVG_SD, RES_ERR<=0, RES_CH<=grant; go to RESP.
  - Timeout counter increments each cycle and resets on ENG_SAMPLE. On reaching TIMEOUT without ENG_DONE: RES_DATA<=0, RES_ERR<=1, RES_CH<=grant; go to RESP.
  - If ENG_DONE and the timeout expire in the same cycle, ENG_DONE wins.
- RESP:
  - RES_VALID=1; ENG_RESET=1 (engine held).
  - RES_DATA, RES_CH and RES_ERR are held stable until RES_ACK.
  - RES_ACK high at an edge: RES_VALID<=0, rr_ptr<=grant, go to IDLE.
  - RES_ACK while RES_VALID=0 is ignored.
- Outside RUN: ENG_TN=0 and CH_SAMPLE=0.
- Latency:
  - REQ at edge k gives CLEAR in cycle k+1 and RUN from k+2.
  - ENG_DONE sampled at edge m gives RES_VALID=1 from m+1.
  - After an ACK, the earliest new grant is at the next edge.
- Fairness:
  - The channel granted last has lowest priority in the next arbitration.
  - With all REQ held high, grants cycle 0,1,2,3,0,...
- REQ deasserting after grant does not cancel the job; REQ is only examined in IDLE.
- Changes on REQ_MODE after grant have no effect until the next job.

Test Plan:
- Single job: REQ=0001, REQ_MODE[0]=0, engine model averages 8 samples of 100..107 and pulses DONE with 103 -> CLEAR lasts 1 cycle, 8 pulses on CH_SAMPLE[0], then RES_VALID=1 with RES_CH=0, RES_DATA=103, RES_ERR=0.
- Fairness: REQ=1111 held high, ACK given 1 cycle after each RES_VALID -> RES_CH sequence 0,1,2,3,0,1.
- Mode and steering: REQ=0100, REQ_MODE=0100, CH_TN[2]=0x0A5 -> ENG_MODE=1, ENG_TN=0x0A5 throughout RUN; CH_SAMPLE[0,1,3] stay 0.
- Backpressure: RES_ACK held low for 20 cycles with REQ=0010 also pending -> RES_VALID and RES_DATA stable, BUSY=1, no new CLEAR until 1 cycle after ACK.
- Timeout: engine never strobes, TIMEOUT=255 -> RES_VALID after 255 RUN cycles with RES_ERR=1, RES_DATA=0; the next requester is granted normally.
- Async reset: RESET_N pulsed low mid-RUN between clock edges -> immediately BUSY=0, RES_VALID=0, ENG_RESET=1; after release, REQ=0001 is granted channel 0 first.

Source files
------------

// File: rtl/noaa_mote_scheduler_if.sv
// -----------------------------------------------------------------------------
// noaa_mote_scheduler_if
// Bundles every signal between the mote scheduler, the mote sample
// front-ends, the shared NOAA statistics engine and the result consumer.
//   req/req_mode/ch_tn        : per-channel request, mode and 12-bit samples
//   ch_sample                 : one-hot "sample consumed" strobe back to motes
//   eng_reset/eng_mode/eng_tn : engine controls and steered sample
//   eng_sample/eng_done/eng_avg_sd : engine status and result
//   res_valid/res_ch/res_data/res_err/res_ack : result handshake
//   busy                      : scheduler not idle
// master = scheduler side, slave = environment side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface noaa_mote_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CHW    = 2
);
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    req_mode;
  logic [NUM_CH*12-1:0] ch_tn;
  logic [NUM_CH-1:0]    ch_sample;
  logic                 eng_reset;
  logic                 eng_mode;
  logic [11:0]          eng_tn;
  logic                 eng_sample;
  logic                 eng_done;
  logic [11:0]          eng_avg_sd;
  logic                 res_valid;
  logic [CHW-1:0]       res_ch;
  logic [11:0]          res_data;
  logic                 res_err;
  logic                 res_ack;
  logic                 busy;

  modport master (
    input  req, req_mode, ch_tn, eng_sample, eng_done, eng_avg_sd, res_ack,
    output ch_sample, eng_reset, eng_mode, eng_tn,
           res_valid, res_ch, res_data, res_err, busy
  );

  modport slave (
    output req, req_mode, ch_tn, eng_sample, eng_done, eng_avg_sd, res_ack,
    input  ch_sample, eng_reset, eng_mode, eng_tn,
           res_valid, res_ch, res_data, res_err, busy
  );
endinterface

// File: rtl/noaa_mote_scheduler.sv
// -----------------------------------------------------------------------------
// noaa_mote_scheduler
// Round-robin scheduler sharing one NOAA statistics engine among NUM_CH
// temperature-mote channels. Each job: grant a requester, clear the engine
// for one cycle, run it with the granted channel's mode and samples, capture
// the result (or a timeout error) and hold it until acknowledged.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : noaa_mote_scheduler_if.master (requests, engine, result)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module noaa_mote_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CHW     = 2,
  parameter int TIMEOUT = 255
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  noaa_mote_scheduler_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CHW-1:0]        r_rr_ptr;
  logic [CHW-1:0]        r_grant;
  logic                  r_eng_mode;
  logic                  r_res_valid;
  logic [CHW-1:0]        r_res_ch;
  logic [11:0]           r_res_data;
  logic                  r_res_err;
  logic [TW-1:0]         r_tmo_cnt;

  logic                  w_found;
  logic [CHW-1:0]        w_pick;
  logic                  w_tmo_exp;
  logic [11:0]           w_eng_tn;
  logic [NUM_CH-1:0]     w_ch_sample;

  // Round-robin pick: first set request strictly after the last grant, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!w_found && bus.req[(int'(r_rr_ptr) + i) % NUM_CH]) begin
        w_found = 1'b1;
        w_pick  = CHW'((int'(r_rr_ptr) + i) % NUM_CH);
      end else begin
        w_found = w_found;
      end
    end
  end

  // A sample strobe in the expiring cycle keeps the job alive.
  assign w_tmo_exp = (r_tmo_cnt == TW'(TIMEOUT - 1)) && !bus.eng_sample;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state decode; DONE takes priority over an expiring timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  begin
        if (w_found) w_next = ST_CLEAR;
        else         w_next = ST_IDLE;
      end
      ST_CLEAR: w_next = ST_RUN;
      ST_RUN:   begin
        if (bus.eng_done)   w_next = ST_RESP;
        else if (w_tmo_exp) w_next = ST_RESP;
        else                w_next = ST_RUN;
      end
      ST_RESP:  begin
        if (bus.res_ack) w_next = ST_IDLE;
        else             w_next = ST_RESP;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Job datapath: grant/mode capture, timeout counting, result capture and release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr    <= CHW'(NUM_CH - 1);
      r_grant     <= '0;
      r_eng_mode  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_data  <= 12'd0;
      r_res_err   <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant    <= w_pick;
            r_eng_mode <= bus.req_mode[w_pick];
          end
        end
        ST_CLEAR: begin
          r_tmo_cnt <= '0;
        end
        ST_RUN: begin
          if (bus.eng_done) begin
            r_res_data  <= bus.eng_avg_sd;
            r_res_err   <= 1'b0;
            r_res_ch    <= r_grant;
            r_res_valid <= 1'b1;
          end else if (w_tmo_exp) begin
            r_res_data  <= 12'd0;
            r_res_err   <= 1'b1;
            r_res_ch    <= r_grant;
            r_res_valid <= 1'b1;
          end else if (bus.eng_sample) begin
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        ST_RESP: begin
          if (bus.res_ack) begin
            r_res_valid <= 1'b0;
            r_rr_ptr    <= r_grant;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sample steering: only the granted channel is connected, and only in RUN.
  always_comb begin
    w_eng_tn    = 12'd0;
    w_ch_sample = '0;
    if (r_state == ST_RUN) begin
      w_eng_tn             = bus.ch_tn[int'(r_grant) * 12 +: 12];
      w_ch_sample[r_grant] = bus.eng_sample;
    end else begin
      w_eng_tn    = 12'd0;
      w_ch_sample = '0;
    end
  end

  assign bus.eng_tn    = w_eng_tn;
  assign bus.ch_sample = w_ch_sample;
  // Engine is held in clear everywhere except RUN (including during reset).
  assign bus.eng_reset = (r_state != ST_RUN);
  assign bus.eng_mode  = r_eng_mode;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_ch    = r_res_ch;
  assign bus.res_data  = r_res_data;
  assign bus.res_err   = r_res_err;

endmodule

// File: tb/tb_noaa_mote_scheduler.sv
`timescale 1ns/1ps
module tb_noaa_mote_scheduler;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  noaa_mote_scheduler_if #(.NUM_CH(4), .CHW(2)) bus ();

  noaa_mote_scheduler #(.NUM_CH(4), .CHW(2), .TIMEOUT(255)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!ok) begin
        if (bus.busy === 1'b1 && bus.eng_reset === 1'b0) ok = 1'b1;
        else tick();
      end
    end
  endtask

  task automatic finish_job(input logic [11:0] val);
    bus.eng_avg_sd = val;
    bus.eng_done   = 1'b1;
    tick();
    bus.eng_done   = 1'b0;
  endtask

  task automatic ack();
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'b0000; bus.req_mode = 4'b0000; bus.ch_tn = 48'd0;
    bus.eng_sample = 1'b0; bus.eng_done = 1'b0; bus.eng_avg_sd = 12'd0; bus.res_ack = 1'b0;
    #12;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.eng_reset !== 1'b1) begin n_fail++; $display("FAIL reset_eng_reset: got %b want 1", bus.eng_reset); end
    n_chk++; if (bus.eng_mode !== 1'b0) begin n_fail++; $display("FAIL reset_eng_mode: got %b want 0", bus.eng_mode); end
    n_chk++; if (bus.res_valid !== 1'b0 || bus.res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res_flags: got v=%b e=%b want 0 0", bus.res_valid, bus.res_err); end
    n_chk++; if (bus.res_ch !== 2'd0 || bus.res_data !== 12'd0) begin n_fail++; $display("FAIL reset_res_data: got ch=%0d d=%h want 0 000", bus.res_ch, bus.res_data); end
    n_chk++; if (bus.eng_tn !== 12'd0 || bus.ch_sample !== 4'b0000) begin n_fail++; $display("FAIL reset_steer: got tn=%h s=%b want 000 0000", bus.eng_tn, bus.ch_sample); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    bit ok;
    bus.req = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      wait_run(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL fair_run_%0d: RUN not reached want RUN", j); end
      finish_job(12'h100 + 12'(j));
      n_chk++; if (bus.res_valid !== 1'b1 || bus.res_ch !== 2'(j % 4)) begin n_fail++; $display("FAIL fair_ch_%0d: got v=%b ch=%0d want 1 %0d", j, bus.res_valid, bus.res_ch, j % 4); end
      n_chk++; if (bus.res_data !== 12'h100 + 12'(j)) begin n_fail++; $display("FAIL fair_data_%0d: got %h want %h", j, bus.res_data, 12'h100 + 12'(j)); end
      tick();
      ack();
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    int pulses;
    pulses = 0;
    bus.req = 4'b0001; bus.req_mode = 4'b0000;
    tick();
    n_chk++; if (bus.busy !== 1'b1 || bus.eng_reset !== 1'b1 || bus.ch_sample !== 4'b0000) begin n_fail++; $display("FAIL single_clear: got busy=%b rst=%b s=%b want 1 1 0000", bus.busy, bus.eng_reset, bus.ch_sample); end
    bus.req = 4'b0000;
    tick();
    n_chk++; if (bus.eng_reset !== 1'b0 || bus.eng_mode !== 1'b0) begin n_fail++; $display("FAIL single_run: got rst=%b mode=%b want 0 0", bus.eng_reset, bus.eng_mode); end
    for (int j = 0; j < 8; j++) begin
      bus.ch_tn[11:0] = 12'(100 + j);
      bus.eng_sample = 1'b1;
      #1;
      if (bus.ch_sample === 4'b0001) pulses++;
      n_chk++; if (bus.eng_tn !== 12'(100 + j)) begin n_fail++; $display("FAIL single_tn_%0d: got %0d want %0d", j, bus.eng_tn, 100 + j); end
      tick();
    end
    bus.eng_sample = 1'b0;
    n_chk++; if (pulses != 8) begin n_fail++; $display("FAIL single_pulses: got %0d want 8", pulses); end
    finish_job(12'd103);
    n_chk++; if (bus.res_valid !== 1'b1 || bus.res_ch !== 2'd0 || bus.res_err !== 1'b0) begin n_fail++; $display("FAIL single_res: got v=%b ch=%0d e=%b want 1 0 0", bus.res_valid, bus.res_ch, bus.res_err); end
    n_chk++; if (bus.res_data !== 12'd103) begin n_fail++; $display("FAIL single_data: got %0d want 103", bus.res_data); end
    ack();
    n_chk++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_ack: got v=%b busy=%b want 0 0", bus.res_valid, bus.busy); end
  endtask

  task automatic test_mode_steer();
    bus.ch_tn = {12'h333, 12'h0A5, 12'h111, 12'h222};
    bus.req = 4'b0100; bus.req_mode = 4'b0100;
    tick();
    n_chk++; if (bus.eng_mode !== 1'b1 || bus.eng_tn !== 12'd0) begin n_fail++; $display("FAIL mode_clear: got mode=%b tn=%h want 1 000", bus.eng_mode, bus.eng_tn); end
    bus.req = 4'b0000; bus.req_mode = 4'b0000;
    tick();
    for (int j = 0; j < 5; j++) begin
      bus.eng_sample = (j % 2 == 1);
      #1;
      n_chk++; if (bus.eng_tn !== 12'h0A5 || bus.eng_mode !== 1'b1) begin n_fail++; $display("FAIL steer_tn_%0d: got tn=%h mode=%b want 0a5 1", j, bus.eng_tn, bus.eng_mode); end
      n_chk++; if (bus.ch_sample !== ((j % 2 == 1) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL steer_sample_%0d: got %b", j, bus.ch_sample); end
      tick();
    end
    bus.eng_sample = 1'b0;
    finish_job(12'h05A);
    n_chk++; if (bus.res_ch !== 2'd2 || bus.res_data !== 12'h05A) begin n_fail++; $display("FAIL steer_res: got ch=%0d d=%h want 2 05a", bus.res_ch, bus.res_data); end
    ack();
  endtask

  task automatic test_back_pressure();
    bit ok;
    bus.req = 4'b0011;
    wait_run(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_run: RUN not reached want RUN"); end
    finish_job(12'h3C3);
    for (int j = 0; j < 20; j++) begin
      n_chk++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 12'h3C3 || bus.res_ch !== 2'd0 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_%0d: got v=%b d=%h ch=%0d busy=%b want 1 3c3 0 1", j, bus.res_valid, bus.res_data, bus.res_ch, bus.busy);
      end
      tick();
    end
    ack();
    n_chk++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got busy=%b v=%b want 0 0", bus.busy, bus.res_valid); end
    tick();
    n_chk++; if (bus.busy !== 1'b1 || bus.eng_reset !== 1'b1) begin n_fail++; $display("FAIL bp_clear: got busy=%b rst=%b want 1 1", bus.busy, bus.eng_reset); end
    bus.req = 4'b0000;
    tick();
    finish_job(12'h0C1);
    n_chk++; if (bus.res_ch !== 2'd1 || bus.res_data !== 12'h0C1) begin n_fail++; $display("FAIL bp_next: got ch=%0d d=%h want 1 0c1", bus.res_ch, bus.res_data); end
    ack();
  endtask

  task automatic test_timeout();
    bus.req = 4'b1000;
    tick();
    bus.req = 4'b0000;
    tick();
    repeat (254) tick();
    n_chk++; if (bus.res_valid !== 1'b0 || bus.eng_reset !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got v=%b rst=%b want 0 0", bus.res_valid, bus.eng_reset); end
    tick();
    n_chk++; if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1 || bus.res_data !== 12'd0 || bus.res_ch !== 2'd3) begin n_fail++; $display("FAIL tmo_res: got v=%b e=%b d=%h ch=%0d want 1 1 000 3", bus.res_valid, bus.res_err, bus.res_data, bus.res_ch); end
    ack();
    // next requester; DONE coincides with the expiring cycle
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    repeat (254) tick();
    finish_job(12'h077);
    n_chk++; if (bus.res_err !== 1'b0 || bus.res_data !== 12'h077 || bus.res_ch !== 2'd0) begin n_fail++; $display("FAIL tmo_done_wins: got e=%b d=%h ch=%0d want 0 077 0", bus.res_err, bus.res_data, bus.res_ch); end
    ack();
    // a sample strobe restarts the count
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    tick();
    repeat (200) tick();
    bus.eng_sample = 1'b1;
    tick();
    bus.eng_sample = 1'b0;
    repeat (200) tick();
    n_chk++; if (bus.res_valid !== 1'b0 || bus.eng_reset !== 1'b0) begin n_fail++; $display("FAIL tmo_restart: got v=%b rst=%b want 0 0", bus.res_valid, bus.eng_reset); end
    finish_job(12'h0AB);
    n_chk++; if (bus.res_err !== 1'b0 || bus.res_ch !== 2'd1 || bus.res_data !== 12'h0AB) begin n_fail++; $display("FAIL tmo_restart_res: got e=%b ch=%0d d=%h want 0 1 0ab", bus.res_err, bus.res_ch, bus.res_data); end
    ack();
  endtask

  task automatic test_async_reset();
    bit ok;
    bus.req = 4'b0001;
    wait_run(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL arst_run: RUN not reached want RUN"); end
    bus.req = 4'b0000;
    bus.eng_sample = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.eng_reset !== 1'b1) begin n_fail++; $display("FAIL arst_now: got busy=%b v=%b rst=%b want 0 0 1", bus.busy, bus.res_valid, bus.eng_reset); end
    n_chk++; if (bus.ch_sample !== 4'b0000) begin n_fail++; $display("FAIL arst_sample: got %b want 0000", bus.ch_sample); end
    bus.eng_sample = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_chk++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL arst_silent: got busy=%b v=%b want 0 0", bus.busy, bus.res_valid); end
    bus.req = 4'b1111;
    tick();
    bus.req = 4'b0000;
    wait_run(ok);
    finish_job(12'h0EE);
    n_chk++; if (bus.res_ch !== 2'd0 || bus.res_data !== 12'h0EE) begin n_fail++; $display("FAIL arst_first: got ch=%0d d=%h want 0 0ee", bus.res_ch, bus.res_data); end
    ack();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_fairness();
    test_single();
    test_mode_steer();
    test_back_pressure();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
